// File: rtl/debug_cmd_pkg.sv
// Shared types and default sizing for the debug command dispatcher.
package debug_cmd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam int DW_DEFAULT          = 38;
  localparam int IRW_DEFAULT         = 2;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/debug_sync_edge.sv
// Multi-flop synchronizer for a JTAG-domain level plus a rising-edge detector.
module debug_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_p0;
  logic              edge_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      edge_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[STAGES-2:0], async_in};
      // stage boundary: synchronized level -> edge-detect history flop
      edge_p1 <= sync_p0[STAGES-1];
    end
  end

  assign rise = sync_p0[STAGES-1] & ~edge_p1;

endmodule

// File: rtl/debug_cmd_dispatch.sv
// Dispatches JTAG update-DR commands into the core clock domain as one-hot pulses.
// Optional saturating drop counter enabled by defining DEBUG_CMD_DISPATCH_OVF_CNT_EN.
module debug_cmd_dispatch
  import debug_cmd_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int IRW         = IRW_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int ACT_BIT     = DW - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vs_uir,
  input  logic                  vs_udr,
  input  logic [IRW-1:0]        ir_in,
  input  logic [DW-1:0]         sr,
  input  logic                  cmd_ready,
  output logic [DW-1:0]         jdo,
  output logic [(1<<IRW)-1:0]   take_action,
  output logic [(1<<IRW)-1:0]   take_no_action,
  output logic                  cmd_pending,
  output logic                  cmd_overflow,
  output logic                  st_ready_test_idle
`ifdef DEBUG_CMD_DISPATCH_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);

  localparam int NCH = 1 << IRW;

  state_t         state, state_nxt;
  logic           uir_rise, udr_rise;
  logic [IRW-1:0] ir_q, ch_q, ch_nxt;
  logic [DW-1:0]  jdo_nxt;
  logic [NCH-1:0] act_nxt, noact_nxt;
  logic           drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  debug_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_uir),
    .rise     (uir_rise)
  );

  debug_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_udr),
    .rise     (udr_rise)
  );

  always_comb begin
    state_nxt = state;
    jdo_nxt   = jdo;
    ch_nxt    = ch_q;
    act_nxt   = '0;
    noact_nxt = '0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (udr_rise) begin
          jdo_nxt   = sr;
          ch_nxt    = ir_q;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (cmd_ready) begin
          if (jdo[ACT_BIT]) act_nxt[ch_q]   = 1'b1;
          else              noact_nxt[ch_q] = 1'b1;
          // A fresh command arriving on the dispatch cycle refills the slot.
          if (udr_rise) begin
            jdo_nxt = sr;
            ch_nxt  = ir_q;
          end else begin
            state_nxt = IDLE;
          end
        end else if (udr_rise) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      jdo            <= '0;
      ir_q           <= '0;
      ch_q           <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      cmd_overflow   <= 1'b0;
    end else begin
      state          <= state_nxt;
      jdo            <= jdo_nxt;
      ch_q           <= ch_nxt;
      take_action    <= act_nxt;
      take_no_action <= noact_nxt;
      cmd_overflow   <= cmd_overflow | drop;
      if (uir_rise) ir_q <= ir_in;
    end
  end

`ifdef DEBUG_CMD_DISPATCH_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)     ovf_count <= 8'd0;
    else if (drop) ovf_count <= sat_inc8(ovf_count);
  end
`endif

  assign cmd_pending        = (state == PEND);
  assign st_ready_test_idle = (state == IDLE);

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// Directed bench for debug_cmd_dispatch with a pulse scoreboard and immediate-assertion checks.
module tb_debug_cmd_dispatch;

  localparam int DW  = 38;
  localparam int IRW = 2;
  localparam int SS  = 2;
  localparam int NCH = 1 << IRW;

  logic           clk = 1'b0;
  logic           reset;
  logic           vs_uir, vs_udr, cmd_ready;
  logic [IRW-1:0] ir_in;
  logic [DW-1:0]  sr;
  logic [DW-1:0]  jdo;
  logic [NCH-1:0] take_action, take_no_action;
  logic           cmd_pending, cmd_overflow, st_ready_test_idle;
`ifdef DEBUG_CMD_DISPATCH_OVF_CNT_EN
  logic [7:0]     ovf_count;
`endif

  typedef struct packed {
    logic [NCH-1:0] act;
    logic [NCH-1:0] noact;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  debug_cmd_dispatch #(.DW(DW), .IRW(IRW), .SYNC_STAGES(SS)) dut (
    .clk                (clk),
    .reset              (reset),
    .vs_uir             (vs_uir),
    .vs_udr             (vs_udr),
    .ir_in              (ir_in),
    .sr                 (sr),
    .cmd_ready          (cmd_ready),
    .jdo                (jdo),
    .take_action        (take_action),
    .take_no_action     (take_no_action),
    .cmd_pending        (cmd_pending),
    .cmd_overflow       (cmd_overflow),
    .st_ready_test_idle (st_ready_test_idle)
`ifdef DEBUG_CMD_DISPATCH_OVF_CNT_EN
    ,
    .ovf_count          (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic uir_pulse(input logic [IRW-1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(SS + 2);
  endtask

  task automatic udr_pulse(input logic [DW-1:0] val);
    sr     = val;
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(SS + 2);
  endtask

  // Scoreboard: every pulse cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en && ((take_action | take_no_action) !== '0)) begin
      chk("pulse_mutex", 64'(take_action & take_no_action), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {56'd0, take_action, take_no_action}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_take_action", 64'(take_action), 64'(e.act));
        chk("sb_take_no_action", 64'(take_no_action), 64'(e.noact));
      end
    end
  end

  initial begin
    reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0;
    ir_in = '0; sr = '0;
    tick(3);
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_act", 64'(take_action), 64'd0);
    chk("rst_noact", 64'(take_no_action), 64'd0);
    chk("rst_pending", 64'(cmd_pending), 64'd0);
    chk("rst_overflow", 64'(cmd_overflow), 64'd0);
    chk("rst_idle", 64'(st_ready_test_idle), 64'd1);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Action command on channel 2 with latency check
    uir_pulse(2'd2);
    cmd_ready = 1'b1;
    sr = 38'h20_0000_0001;
    exp_q.push_back('{act: 4'b0100, noact: 4'b0000});
    vs_udr = 1'b1;
    tick(SS + 1);
    chk("act_early", 64'(take_action), 64'd0);
    tick(1);
    chk("act_pulse", 64'(take_action), 64'h4);
    chk("act_jdo", 64'(jdo), 64'h20_0000_0001);
    vs_udr = 1'b0;
    tick(1);
    chk("act_one_cycle", 64'(take_action), 64'd0);
    tick(SS + 2);

    // No-action command on channel 0
    uir_pulse(2'd0);
    sr = 38'h1F_0000_0002;
    exp_q.push_back('{act: 4'b0000, noact: 4'b0001});
    vs_udr = 1'b1;
    tick(SS + 2);
    chk("noact_pulse", 64'(take_no_action), 64'h1);
    chk("noact_act_zero", 64'(take_action), 64'd0);
    vs_udr = 1'b0;
    tick(SS + 2);

    // Drop while pending, then a single dispatch
    cmd_ready = 1'b0;
    uir_pulse(2'd3);
    udr_pulse(38'h20_0000_00AA);
    chk("hold_pending", 64'(cmd_pending), 64'd1);
    chk("hold_no_ovf", 64'(cmd_overflow), 64'd0);
    udr_pulse(38'h00_0000_0055);
    chk("drop_pending", 64'(cmd_pending), 64'd1);
    chk("drop_overflow", 64'(cmd_overflow), 64'd1);
    chk("drop_jdo_kept", 64'(jdo), 64'h20_0000_00AA);
    exp_q.push_back('{act: 4'b1000, noact: 4'b0000});
    cmd_ready = 1'b1;
    tick(1);
    chk("drop_dispatch", 64'(take_action), 64'h8);
    tick(5);
    chk("drop_idle", 64'(cmd_pending), 64'd0);
    chk("ovf_sticky", 64'(cmd_overflow), 64'd1);

    // Reset while a command is pending discards it
    cmd_ready = 1'b0;
    udr_pulse(38'h20_0000_0777);
    chk("rp_pending", 64'(cmd_pending), 64'd1);
    reset = 1'b1;
    tick(1);
    chk("rp_jdo", 64'(jdo), 64'd0);
    chk("rp_pulses", {56'd0, take_action, take_no_action}, 64'd0);
    chk("rp_pending_clr", 64'(cmd_pending), 64'd0);
    chk("rp_overflow_clr", 64'(cmd_overflow), 64'd0);
    chk("rp_idle", 64'(st_ready_test_idle), 64'd1);
    reset = 1'b0;
    cmd_ready = 1'b1;
    tick(10);
    chk("rp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Second command arrives on the dispatch cycle
    cmd_ready = 1'b0;
    uir_pulse(2'd1);
    udr_pulse(38'h20_0000_1111);
    uir_pulse(2'd2);
    exp_q.push_back('{act: 4'b0010, noact: 4'b0000});
    exp_q.push_back('{act: 4'b0000, noact: 4'b0100});
    sr = 38'h00_0000_2222;
    vs_udr = 1'b1;
    tick(SS);
    cmd_ready = 1'b1;
    tick(1);
    chk("coin_first", 64'(take_action), 64'h2);
    chk("coin_jdo", 64'(jdo), 64'h00_0000_2222);
    tick(1);
    chk("coin_second", 64'(take_no_action), 64'h4);
    chk("coin_no_ovf", 64'(cmd_overflow), 64'd0);
    chk("coin_idle", 64'(cmd_pending), 64'd0);
    vs_udr = 1'b0;
    tick(SS + 2);

    // vs_udr already high at reset release
    reset = 1'b1;
    sr = 38'h20_0000_0F0F;
    vs_udr = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_q.push_back('{act: 4'b0001, noact: 4'b0000});
    tick(1);
    chk("rel_no_edge", 64'(cmd_pending), 64'd0);
    tick(3);
    chk("rel_pulse", 64'(take_action), 64'h1);
    vs_udr = 1'b0;
    tick(SS + 2);

`ifdef DEBUG_CMD_DISPATCH_OVF_CNT_EN
    cmd_ready = 1'b0;
    udr_pulse(38'h00_0000_0001);
    for (int i = 0; i < 300; i++) udr_pulse(38'h00_0000_0002);
    chk("ovf_count_sat", 64'(ovf_count), 64'd255);
    reset = 1'b1;
    tick(1);
    chk("ovf_count_rst", 64'(ovf_count), 64'd0);
    reset = 1'b0;
    tick(2);
`endif

    tick(2);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
